// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase sequencer: default count lengths,
// lamp encodings and the phase state encoding.
package traffic_pkg;

  // Default count lengths loaded into the down-counter for each phase kind
  localparam logic [3:0] DEF_GREEN_MODE  = 4'd9;
  localparam logic [3:0] DEF_YELLOW_MODE = 4'd5;
  localparam logic [3:0] DEF_ALLRED_MODE = 4'd1;
  localparam logic [3:0] DEF_WALK_MODE   = 4'd9;

  // Lamp encodings, {Red,Yellow,Green}, one-hot
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Phase encoding; PH_PED is only reachable when the walk phase is built in
  typedef enum logic [2:0] {
    PH_AR_NS = 3'd0,
    PH_NS_G  = 3'd1,
    PH_NS_Y  = 3'd2,
    PH_AR_EW = 3'd3,
    PH_EW_G  = 3'd4,
    PH_EW_Y  = 3'd5,
    PH_PED   = 3'd6
  } phase_e;

  // True when the counter has reached its terminal value
  function automatic logic count_is_zero(input logic [3:0] count);
    count_is_zero = (count == 4'd0);
  endfunction

endpackage

// File: rtl/phase_expiry_det.sv
// Count-expiry detector. A phase may only expire after the counter has been
// seen non-zero during that phase, so a zero left over from the previous
// phase cannot advance the sequencer twice in a row.
module phase_expiry_det
  import traffic_pkg::*;
(
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Enable,
  input  logic [3:0] Count,
  output logic       expiry
);

  logic armed_r;
  logic count_zero_s;

  assign count_zero_s = count_is_zero(Count);
  assign expiry       = Enable & armed_r & count_zero_s;

  // Arm on a live non-zero count, disarm on the expiry edge, hold while frozen
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      armed_r <= 1'b0;
    end else if (expiry) begin
      armed_r <= 1'b0;
    end else if (Enable && !count_zero_s) begin
      armed_r <= 1'b1;
    end else begin
      armed_r <= armed_r;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic phase sequencer sitting in front of the 4-bit down-counter.
// Walks NS green/yellow, all-red, EW green/yellow, all-red, loading the
// counter's Mode for each phase. All outputs come straight from flops.
// Build option: TRAFFIC_PED_EN adds a pedestrian walk phase after EW yellow
// when a request is pending; without it PedReq is ignored and PedWalk is 0.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter logic [3:0] GREEN_MODE  = DEF_GREEN_MODE,
  parameter logic [3:0] YELLOW_MODE = DEF_YELLOW_MODE,
  parameter logic [3:0] ALLRED_MODE = DEF_ALLRED_MODE,
  parameter logic [3:0] WALK_MODE   = DEF_WALK_MODE
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Enable,
  input  logic [3:0] Count,
  input  logic       PedReq,
  output logic [3:0] Mode,
  output logic       CntEnable,
  output logic [2:0] LightNS,
  output logic [2:0] LightEW,
  output logic       PedWalk
);

  localparam logic [2:0] ST_AR_NS = PH_AR_NS;
  localparam logic [2:0] ST_NS_G  = PH_NS_G;
  localparam logic [2:0] ST_NS_Y  = PH_NS_Y;
  localparam logic [2:0] ST_AR_EW = PH_AR_EW;
  localparam logic [2:0] ST_EW_G  = PH_EW_G;
  localparam logic [2:0] ST_EW_Y  = PH_EW_Y;
`ifdef TRAFFIC_PED_EN
  localparam logic [2:0] ST_PED   = PH_PED;
`endif

  logic       expiry_s;
  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  logic [3:0] mode_r;
  logic [3:0] mode_nxt_s;
  logic [2:0] ns_r;
  logic [2:0] ns_nxt_s;
  logic [2:0] ew_r;
  logic [2:0] ew_nxt_s;
  logic       cnt_en_r;
  logic       walk_nxt_s;

  phase_expiry_det u_expiry (
    .Clk    (Clk),
    .nReset (nReset),
    .Enable (Enable),
    .Count  (Count),
    .expiry (expiry_s)
  );

`ifdef TRAFFIC_PED_EN
  logic ped_pending_r;
  logic walk_r;
`else
  logic       unused_ped_req_s;
  logic [3:0] unused_walk_mode_s;
  assign unused_ped_req_s   = PedReq;
  assign unused_walk_mode_s = WALK_MODE;
`endif

  // Phase sequencing: advance exactly one phase per expiry pulse
  always_comb begin
    state_nxt_s = state_r;
    if (expiry_s) begin
      case (state_r)
        ST_AR_NS: state_nxt_s = ST_NS_G;
        ST_NS_G:  state_nxt_s = ST_NS_Y;
        ST_NS_Y:  state_nxt_s = ST_AR_EW;
        ST_AR_EW: state_nxt_s = ST_EW_G;
        ST_EW_G:  state_nxt_s = ST_EW_Y;
`ifdef TRAFFIC_PED_EN
        ST_EW_Y: begin
          if (ped_pending_r) begin
            state_nxt_s = ST_PED;
          end else begin
            state_nxt_s = ST_AR_NS;
          end
        end
        ST_PED:   state_nxt_s = ST_AR_NS;
`else
        ST_EW_Y:  state_nxt_s = ST_AR_NS;
`endif
        default:  state_nxt_s = ST_AR_NS;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output decode from the next phase so lamps and Mode change on the expiry edge
  always_comb begin
    mode_nxt_s = ALLRED_MODE;
    ns_nxt_s   = LAMP_RED;
    ew_nxt_s   = LAMP_RED;
    walk_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_AR_NS: begin mode_nxt_s = ALLRED_MODE; ns_nxt_s = LAMP_RED; ew_nxt_s = LAMP_RED; end
      ST_NS_G:  begin mode_nxt_s = GREEN_MODE;  ns_nxt_s = LAMP_GRN; ew_nxt_s = LAMP_RED; end
      ST_NS_Y:  begin mode_nxt_s = YELLOW_MODE; ns_nxt_s = LAMP_YEL; ew_nxt_s = LAMP_RED; end
      ST_AR_EW: begin mode_nxt_s = ALLRED_MODE; ns_nxt_s = LAMP_RED; ew_nxt_s = LAMP_RED; end
      ST_EW_G:  begin mode_nxt_s = GREEN_MODE;  ns_nxt_s = LAMP_RED; ew_nxt_s = LAMP_GRN; end
      ST_EW_Y:  begin mode_nxt_s = YELLOW_MODE; ns_nxt_s = LAMP_RED; ew_nxt_s = LAMP_YEL; end
`ifdef TRAFFIC_PED_EN
      ST_PED: begin
        mode_nxt_s = WALK_MODE;
        ns_nxt_s   = LAMP_RED;
        ew_nxt_s   = LAMP_RED;
        walk_nxt_s = 1'b1;
      end
`endif
      default:  begin mode_nxt_s = ALLRED_MODE; ns_nxt_s = LAMP_RED; ew_nxt_s = LAMP_RED; end
    endcase
  end

  // Phase and output registers; counter enable simply follows Enable one edge later
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_r  <= ST_AR_NS;
      mode_r   <= ALLRED_MODE;
      ns_r     <= LAMP_RED;
      ew_r     <= LAMP_RED;
      cnt_en_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      mode_r   <= mode_nxt_s;
      ns_r     <= ns_nxt_s;
      ew_r     <= ew_nxt_s;
      cnt_en_r <= Enable;
    end
  end

`ifdef TRAFFIC_PED_EN
  // Pedestrian request latch; a new request wins over the clear on PED entry
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      ped_pending_r <= 1'b0;
      walk_r        <= 1'b0;
    end else begin
      walk_r <= walk_nxt_s;
      if (PedReq) begin
        ped_pending_r <= 1'b1;
      end else if ((state_nxt_s == ST_PED) && (state_r != ST_PED)) begin
        ped_pending_r <= 1'b0;
      end else begin
        ped_pending_r <= ped_pending_r;
      end
    end
  end

  assign PedWalk = walk_r;
`else
  logic unused_walk_nxt_s;
  assign unused_walk_nxt_s = walk_nxt_s;
  assign PedWalk           = 1'b0;
`endif

  assign Mode      = mode_r;
  assign CntEnable = cnt_en_r;
  assign LightNS   = ns_r;
  assign LightEW   = ew_r;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl. Count is driven directly as if
// from the down-counter; a behavioural phase model predicts the outputs.
module tb_traffic_phase_ctrl;

  logic       Clk    = 1'b0;
  logic       nReset = 1'b1;
  logic       Enable = 1'b0;
  logic [3:0] Count  = 4'd0;
  logic       PedReq = 1'b0;
  logic [3:0] Mode;
  logic       CntEnable;
  logic [2:0] LightNS;
  logic [2:0] LightEW;
  logic       PedWalk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } sb_t;
  sb_t sb_q[$];

  // model: 0 AR_NS,1 NS_G,2 NS_Y,3 AR_EW,4 EW_G,5 EW_Y,6 PED
  int m_state = 0;
  bit m_armed = 1'b0;
  bit m_ped   = 1'b0;

  logic [5:0] prev_combo = 6'b100100;
  logic [5:0] prev2_combo = 6'b100100;
  bit         hist_valid = 1'b0;

`ifdef TRAFFIC_PED_EN
  localparam bit PED_BUILT = 1'b1;
`else
  localparam bit PED_BUILT = 1'b0;
`endif

  always #5 Clk = ~Clk;

  traffic_phase_ctrl dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .Enable    (Enable),
    .Count     (Count),
    .PedReq    (PedReq),
    .Mode      (Mode),
    .CntEnable (CntEnable),
    .LightNS   (LightNS),
    .LightEW   (LightEW),
    .PedWalk   (PedWalk)
  );

  // {Mode, CntEnable, LightNS, LightEW, PedWalk} expected for a phase
  function automatic logic [11:0] expect_of(input int st, input bit en);
    case (st)
      0: expect_of = {4'd1, en, 3'b100, 3'b100, 1'b0};
      1: expect_of = {4'd9, en, 3'b001, 3'b100, 1'b0};
      2: expect_of = {4'd5, en, 3'b010, 3'b100, 1'b0};
      3: expect_of = {4'd1, en, 3'b100, 3'b100, 1'b0};
      4: expect_of = {4'd9, en, 3'b100, 3'b001, 1'b0};
      5: expect_of = {4'd5, en, 3'b100, 3'b010, 1'b0};
      6: expect_of = {4'd9, en, 3'b100, 3'b100, 1'b1};
      default: expect_of = 12'hfff;
    endcase
  endfunction

  function automatic int next_of(input int st, input bit ped);
    case (st)
      5: next_of = (PED_BUILT && ped) ? 6 : 0;
      6: next_of = 0;
      default: next_of = st + 1;
    endcase
  endfunction

  function automatic logic [11:0] observed();
    observed = {Mode, CntEnable, LightNS, LightEW, PedWalk};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: predict, push, clock, pop and compare
  task automatic apply(input logic [3:0] c, input bit en, input bit pr, input string tag);
    bit   exp_s;
    int   nxt;
    sb_t  e;
    logic [5:0] combo;
    @(negedge Clk);
    Count  = c;
    Enable = en;
    PedReq = pr;
    exp_s = en && m_armed && (c == 4'd0);
    nxt   = m_state;
    if (exp_s) nxt = next_of(m_state, m_ped);
    if (PED_BUILT) begin
      if (pr) m_ped = 1'b1;
      else if (nxt == 6 && m_state != 6) m_ped = 1'b0;
    end
    if (en) begin
      if (exp_s) m_armed = 1'b0;
      else if (c != 4'd0) m_armed = 1'b1;
    end
    m_state = nxt;
    sb_q.push_back('{tag, expect_of(m_state, en)});
    @(posedge Clk);
    #1;
    e = sb_q.pop_front();
    check(e.tag, observed(), e.exp);
    check_bit("no_dual_green", LightNS[0] & LightEW[0], 1'b0);
    combo = {LightNS, LightEW};
    if (combo != prev_combo) begin
      if ((combo[3] | combo[0]) && hist_valid) begin
        check_bit("green_after_yel_ar",
                  (prev_combo == 6'b100100) && (prev2_combo[4] | prev2_combo[1]), 1'b1);
      end
      prev2_combo = prev_combo;
      prev_combo  = combo;
      hist_valid  = 1'b1;
    end
  endtask

  task automatic run_phase(input int len, input string tag);
    for (int k = len; k >= 0; k--) apply(k[3:0], 1'b1, 1'b0, tag);
  endtask

  // Asynchronous reset asserted between clock edges and checked before any edge
  task automatic async_reset(input string tag);
    @(posedge Clk);
    #2;
    nReset = 1'b0;
    Enable = 1'b0;
    Count  = 4'd0;
    PedReq = 1'b0;
    #1;
    check(tag, observed(), {4'd1, 1'b0, 3'b100, 3'b100, 1'b0});
    m_state = 0;
    m_armed = 1'b0;
    m_ped   = 1'b0;
    prev_combo  = 6'b100100;
    prev2_combo = 6'b100100;
    hist_valid  = 1'b0;
    @(negedge Clk);
    nReset = 1'b1;
  endtask

  initial begin
    #2;
    nReset = 1'b0;
    #1;
    check("reset_init", observed(), {4'd1, 1'b0, 3'b100, 3'b100, 1'b0});
    @(negedge Clk);
    nReset = 1'b1;

    // Normal cycle through all six phases
    run_phase(1, "ar_ns");
    check("to_ns_g", observed(), {4'd9, 1'b1, 3'b001, 3'b100, 1'b0});
    run_phase(9, "ns_g");
    check("to_ns_y", observed(), {4'd5, 1'b1, 3'b010, 3'b100, 1'b0});
    run_phase(5, "ns_y");
    check("to_ar_ew", observed(), {4'd1, 1'b1, 3'b100, 3'b100, 1'b0});
    run_phase(1, "ar_ew");
    check("to_ew_g", observed(), {4'd9, 1'b1, 3'b100, 3'b001, 1'b0});
    run_phase(9, "ew_g");
    check("to_ew_y", observed(), {4'd5, 1'b1, 3'b100, 3'b010, 1'b0});
    run_phase(5, "ew_y");
    check("to_ar_ns", observed(), {4'd1, 1'b1, 3'b100, 3'b100, 1'b0});

    // Stale zero: entering NS_G with Count stuck at 0 must not advance
    run_phase(1, "stale_ar");
    for (int k = 0; k < 3; k++) apply(4'd0, 1'b1, 1'b0, "stale_hold");
    check("stale_still_ns_g", observed(), {4'd9, 1'b1, 3'b001, 3'b100, 1'b0});
    apply(4'd9, 1'b1, 1'b0, "stale_rearm");
    apply(4'd0, 1'b1, 1'b0, "stale_expire");
    check("stale_to_ns_y", observed(), {4'd5, 1'b1, 3'b010, 3'b100, 1'b0});

    // Freeze in EW_G at Count 4, then resume
    run_phase(5, "frz_ns_y");
    run_phase(1, "frz_ar_ew");
    for (int k = 9; k >= 4; k--) apply(k[3:0], 1'b1, 1'b0, "frz_ew_g");
    for (int k = 0; k < 5; k++) apply(4'd0, 1'b0, 1'b0, "frz_hold");
    check("frz_held", observed(), {4'd9, 1'b0, 3'b100, 3'b001, 1'b0});
    for (int k = 4; k >= 1; k--) apply(k[3:0], 1'b1, 1'b0, "frz_resume");
    check("frz_resumed", observed(), {4'd9, 1'b1, 3'b100, 3'b001, 1'b0});
    apply(4'd0, 1'b1, 1'b0, "frz_expire");
    check("frz_to_ew_y", observed(), {4'd5, 1'b1, 3'b100, 3'b010, 1'b0});
    for (int k = 5; k >= 0; k--) apply(k[3:0], 1'b1, 1'b0, "frz_ew_y");
    check("no_ped_to_ar_ns", observed(), {4'd1, 1'b1, 3'b100, 3'b100, 1'b0});

    // Count above 9 arms like any non-zero value
    apply(4'd15, 1'b1, 1'b0, "cnt_big");
    apply(4'd0, 1'b1, 1'b0, "cnt_big_expire");
    check("big_to_ns_g", observed(), {4'd9, 1'b1, 3'b001, 3'b100, 1'b0});

    // Pedestrian request raised during NS_G
    apply(4'd9, 1'b1, 1'b1, "ped_req");
    for (int k = 8; k >= 0; k--) apply(k[3:0], 1'b1, 1'b0, "ped_ns_g");
    run_phase(5, "ped_ns_y");
    run_phase(1, "ped_ar_ew");
    run_phase(9, "ped_ew_g");
    run_phase(5, "ped_ew_y");
`ifdef TRAFFIC_PED_EN
    check("ped_phase", observed(), {4'd9, 1'b1, 3'b100, 3'b100, 1'b1});
    run_phase(9, "ped_walk");
    check("ped_to_ar_ns", observed(), {4'd1, 1'b1, 3'b100, 3'b100, 1'b0});
`else
    check("ped_ignored", observed(), {4'd1, 1'b1, 3'b100, 3'b100, 1'b0});
`endif

    // Reset asserted mid-phase
    run_phase(1, "mid_ar");
    apply(4'd9, 1'b1, 1'b0, "mid_ns_g");
    apply(4'd8, 1'b1, 1'b0, "mid_ns_g");
    async_reset("reset_mid_phase");

    // Random Count/Enable/PedReq
    for (int i = 0; i < 10000; i++) begin
      logic [3:0] c;
      bit en;
      bit pr;
      c  = 4'($urandom_range(15, 0));
      if ($urandom_range(3, 0) == 0) c = 4'd0;
      en = ($urandom_range(7, 0) != 0);
      pr = ($urandom_range(15, 0) == 0);
      apply(c, en, pr, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
